// File: rtl/lc3_ctrl_pkg.sv
// lc3_ctrl_pkg: state encoding, opcodes and datapath mux encodings shared by the LC-3 control FSM.
package lc3_ctrl_pkg;
  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12,
    S04, S21, S20, S06, S25, S27, S07, S23, S16, PAUSE1, PAUSE2
  } state_t;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_BR = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_PSE = 4'b1101;
  localparam logic [1:0] ALUK_ADD = 2'b00;
  localparam logic [1:0] ALUK_AND = 2'b01;
  localparam logic [1:0] ALUK_NOT = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;
  localparam logic [1:0] PC_PLUS1 = 2'b00;
  localparam logic [1:0] PC_BUS = 2'b01;
  localparam logic [1:0] PC_ADDER = 2'b10;
  localparam logic [1:0] A2_ZERO = 2'b00;
  localparam logic [1:0] A2_OFF6 = 2'b01;
  localparam logic [1:0] A2_OFF9 = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;
endpackage

// File: rtl/lc3_control_fsm_mem_wait_counter.sv
// mem_wait_counter: saturating count of cycles spent in a memory-access state.
module mem_wait_counter #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);
  logic [2:0] cnt_q, cnt_d;
  assign done = cnt_q == 3'(MEM_WAIT - 1);
  always_comb cnt_d = clr ? 3'd0 : (en && !done) ? cnt_q + 3'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: Moore control unit sequencing LC-3 fetch, decode and a subset of execute states.
module lc3_control_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE
);
  state_t state_q, state_d;
  logic in_wait, done;
  assign in_wait = state_q inside {S33, S25, S16};
  // Count is held at zero outside the access states, so every entry starts fresh.
  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk(Clk),
    .rst_n(Reset),
    .clr(!in_wait),
    .en(in_wait),
    .done(done)
  );
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state_q <= HALTED;
    else state_q <= state_d;
  always_comb begin
    state_d = HALTED;
    case (state_q)
      HALTED: state_d = Run ? S18 : HALTED;
      S18: state_d = S33;
      S33: state_d = done ? S35 : S33;
      S35: state_d = S32;
      S32:
        case (Opcode)
          OP_ADD: state_d = S01;
          OP_AND: state_d = S05;
          OP_NOT: state_d = S09;
          OP_BR: state_d = S00;
          OP_JMP: state_d = S12;
          OP_JSR: state_d = S04;
          OP_LDR: state_d = S06;
          OP_STR: state_d = S07;
          OP_PSE: state_d = PAUSE1;
          default: state_d = S18;
        endcase
      S00: state_d = BEN ? S22 : S18;
      S04: state_d = IR_11 ? S21 : S20;
      S06: state_d = S25;
      S25: state_d = done ? S27 : S25;
      S07: state_d = S23;
      S23: state_d = S16;
      S16: state_d = done ? S18 : S16;
      PAUSE1: state_d = Continue ? PAUSE2 : PAUSE1;
      PAUSE2: state_d = Continue ? PAUSE2 : S18;
      S01, S05, S09, S22, S12, S21, S20, S27: state_d = S18;
      default: state_d = HALTED;
    endcase
  end
  always_comb begin
    LD_MAR = 1'b0;
    LD_MDR = 1'b0;
    LD_IR = 1'b0;
    LD_BEN = 1'b0;
    LD_CC = 1'b0;
    LD_REG = 1'b0;
    LD_PC = 1'b0;
    LD_LED = 1'b0;
    GatePC = 1'b0;
    GateMDR = 1'b0;
    GateALU = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX = PC_PLUS1;
    ADDR2MUX = A2_ZERO;
    ALUK = ALUK_ADD;
    DRMUX = 1'b0;
    SR1MUX = 1'b0;
    SR2MUX = 1'b0;
    ADDR1MUX = 1'b0;
    MIO_EN = 1'b0;
    Mem_OE = 1'b1;
    Mem_WE = 1'b1;
    case (state_q)
      S18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC = 1'b1;
        PCMUX = PC_PLUS1;
      end
      S33, S25: begin
        Mem_OE = 1'b0;
        MIO_EN = 1'b1;
        LD_MDR = done;
      end
      S35: begin
        GateMDR = 1'b1;
        LD_IR = 1'b1;
      end
      S32: LD_BEN = 1'b1;
      S01, S05, S09: begin
        GateALU = 1'b1;
        LD_REG = 1'b1;
        LD_CC = 1'b1;
        SR2MUX = state_q != S09 && IR_5;
        ALUK = state_q == S09 ? ALUK_NOT : state_q == S05 ? ALUK_AND : ALUK_ADD;
      end
      S22: begin
        LD_PC = 1'b1;
        PCMUX = PC_ADDER;
        ADDR2MUX = A2_OFF9;
      end
      S12, S20: begin
        LD_PC = 1'b1;
        PCMUX = PC_ADDER;
        ADDR1MUX = 1'b1;
      end
      S04: begin
        GatePC = 1'b1;
        LD_REG = 1'b1;
        DRMUX = 1'b1;
      end
      S21: begin
        LD_PC = 1'b1;
        PCMUX = PC_ADDER;
        ADDR2MUX = A2_OFF11;
      end
      S06, S07: begin
        GateMARMUX = 1'b1;
        LD_MAR = 1'b1;
        ADDR1MUX = 1'b1;
        ADDR2MUX = A2_OFF6;
      end
      S27: begin
        GateMDR = 1'b1;
        LD_REG = 1'b1;
        LD_CC = 1'b1;
      end
      S23: begin
        GateALU = 1'b1;
        ALUK = ALUK_PASSA;
        LD_MDR = 1'b1;
      end
      S16: Mem_WE = 1'b0;
      PAUSE1: LD_LED = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: directed scenarios plus randomized run against a per-instruction output-sequence model.
module tb_lc3_control_fsm;
  localparam int MW = 2;
  localparam int M_HALT = 0, M_Q = 1, M_P1 = 2, M_P2 = 3;
  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic drmux, sr1mux, sr2mux, addr1mux, mio_en, mem_oe, mem_we;
  } ow_t;
  logic Clk = 1'b0, Reset = 1'b0, Run = 1'b0, Continue = 1'b0;
  logic [3:0] Opcode = 4'b0;
  logic IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;
  ow_t got, cur;
  ow_t q[$];
  int total = 0, bad = 0;
  int mode;
  bit new_instr, pause_pending;

  lc3_control_fsm #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  assign got = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
                DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE};

  always #5 Clk = ~Clk;

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, g, e, $time);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic fetch4();
    repeat (3 + MW) step();
  endtask

  function automatic ow_t idle_w();
    ow_t w;
    w = '0;
    w.mem_oe = 1'b1;
    w.mem_we = 1'b1;
    return w;
  endfunction

  function automatic ow_t fetch_w();
    ow_t w = idle_w();
    w.gate_pc = 1'b1;
    w.ld_mar = 1'b1;
    w.ld_pc = 1'b1;
    return w;
  endfunction

  function automatic ow_t led_w();
    ow_t w = idle_w();
    w.ld_led = 1'b1;
    return w;
  endfunction

  task automatic push_reads();
    ow_t w;
    for (int k = 0; k < MW; k++) begin
      w = idle_w();
      w.mem_oe = 1'b0;
      w.mio_en = 1'b1;
      w.ld_mdr = (k == MW - 1);
      q.push_back(w);
    end
  endtask

  function automatic ow_t marmux_w();
    ow_t w = idle_w();
    w.gate_marmux = 1'b1;
    w.ld_mar = 1'b1;
    w.addr1mux = 1'b1;
    w.addr2mux = 2'b01;
    return w;
  endfunction

  // Everything after the opening S18 word: memory read, IR load, decode, then the instruction's execute words.
  task automatic push_instr(input logic [3:0] op, input logic i5, input logic i11, input logic b);
    ow_t w;
    push_reads();
    w = idle_w(); w.gate_mdr = 1'b1; w.ld_ir = 1'b1; q.push_back(w);
    w = idle_w(); w.ld_ben = 1'b1; q.push_back(w);
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        w = idle_w();
        w.gate_alu = 1'b1; w.ld_reg = 1'b1; w.ld_cc = 1'b1;
        w.sr2mux = (op != 4'b1001) && i5;
        w.aluk = op == 4'b0001 ? 2'd0 : op == 4'b0101 ? 2'd1 : 2'd2;
        q.push_back(w);
      end
      4'b0000: begin
        q.push_back(idle_w());
        if (b) begin
          w = idle_w(); w.ld_pc = 1'b1; w.pcmux = 2'd2; w.addr2mux = 2'd2; q.push_back(w);
        end
      end
      4'b1100: begin
        w = idle_w(); w.ld_pc = 1'b1; w.pcmux = 2'd2; w.addr1mux = 1'b1; q.push_back(w);
      end
      4'b0100: begin
        w = idle_w(); w.gate_pc = 1'b1; w.ld_reg = 1'b1; w.drmux = 1'b1; q.push_back(w);
        w = idle_w(); w.ld_pc = 1'b1; w.pcmux = 2'd2;
        if (i11) w.addr2mux = 2'd3;
        else w.addr1mux = 1'b1;
        q.push_back(w);
      end
      4'b0110: begin
        q.push_back(marmux_w());
        push_reads();
        w = idle_w(); w.gate_mdr = 1'b1; w.ld_reg = 1'b1; w.ld_cc = 1'b1; q.push_back(w);
      end
      4'b0111: begin
        q.push_back(marmux_w());
        w = idle_w(); w.gate_alu = 1'b1; w.aluk = 2'd3; w.ld_mdr = 1'b1; q.push_back(w);
        w = idle_w(); w.mem_we = 1'b0;
        repeat (MW) q.push_back(w);
      end
      4'b1101: pause_pending = 1'b1;
      default: ;
    endcase
  endtask

  initial begin
    // Directed scenarios with hand-derived values.
    #2;
    chk("rst_oe_we", {Mem_OE, Mem_WE}, 2'b11);
    chk("rst_gates", {GatePC, GateMDR, GateALU, GateMARMUX}, 4'b0);
    chk("rst_loads", {LD_MAR, LD_MDR, LD_IR, LD_PC}, 4'b0);
    step();
    Reset = 1'b1;
    step();
    chk("halted_idle", got, 25'h0000003);
    Opcode = 4'b0001; IR_5 = 1'b1; Run = 1'b1;
    step();
    Run = 1'b0;
    chk("s18_gatepc", {GatePC, LD_MAR, LD_PC, PCMUX}, 5'b11100);
    step();
    chk("s33a", {Mem_OE, MIO_EN, LD_MDR}, 3'b010);
    step();
    chk("s33b", {Mem_OE, MIO_EN, LD_MDR}, 3'b011);
    step();
    chk("s35", {GateMDR, LD_IR, Mem_OE}, 3'b111);
    step();
    chk("s32", {LD_BEN, GatePC, GateMDR}, 3'b100);
    step();
    chk("s01", {GateALU, LD_REG, LD_CC, SR2MUX, ALUK}, 6'b111100);
    step();
    chk("s01_to_s18", GatePC, 1'b1);
    Opcode = 4'b0000; BEN = 1'b0;
    fetch4();
    chk("s00_ben0", got, 25'h0000003);
    step();
    chk("s00_to_s18", GatePC, 1'b1);
    BEN = 1'b1;
    fetch4();
    chk("s00_ben1", got, 25'h0000003);
    step();
    chk("s22", {LD_PC, PCMUX, ADDR2MUX, ADDR1MUX}, 6'b110100);
    step();
    Opcode = 4'b0111;
    fetch4();
    chk("s07", {GateMARMUX, LD_MAR, ADDR1MUX, ADDR2MUX}, 5'b11101);
    step();
    chk("s23", {GateALU, ALUK, LD_MDR, MIO_EN}, 5'b11110);
    step();
    chk("s16a", {Mem_WE, Mem_OE}, 2'b01);
    step();
    chk("s16b", {Mem_WE, Mem_OE}, 2'b01);
    step();
    chk("s16_to_s18", {Mem_WE, GatePC}, 2'b11);
    Opcode = 4'b1101;
    fetch4();
    chk("pause1", LD_LED, 1'b1);
    step();
    chk("pause1_hold", LD_LED, 1'b1);
    Continue = 1'b1;
    step();
    chk("pause2", got, 25'h0000003);
    Continue = 1'b0;
    step();
    chk("pause_to_s18", GatePC, 1'b1);
    Opcode = 4'b0111;
    fetch4();
    step();
    step();
    chk("s16_before_rst", Mem_WE, 1'b0);
    Reset = 1'b0;
    #1;
    chk("rst_mid_s16_we", Mem_WE, 1'b1);
    chk("rst_mid_s16_gates", {GatePC, GateMDR, GateALU, GateMARMUX}, 4'b0);
    step();
    Reset = 1'b1;
    step();
    chk("after_rst_halted", got, 25'h0000003);

    // Randomized run checked against the sequence model.
    mode = M_HALT;
    q.delete();
    new_instr = 1'b0;
    pause_pending = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      Reset = 1'b1;
      cur = (mode == M_HALT || mode == M_P2) ? idle_w() : mode == M_P1 ? led_w() : q[0];
      chk("rand_out", got, cur);
      chk("one_gate", 32'($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1), 1);
      if ($urandom_range(199) == 0) begin
        Reset = 1'b0;
        #1;
        chk("rand_rst", got, idle_w());
        mode = M_HALT;
        q.delete();
        new_instr = 1'b0;
        pause_pending = 1'b0;
        continue;
      end
      if (new_instr) begin
        Opcode = 4'($urandom_range(15));
        IR_5 = 1'($urandom_range(1));
        IR_11 = 1'($urandom_range(1));
        BEN = 1'($urandom_range(1));
        push_instr(Opcode, IR_5, IR_11, BEN);
        new_instr = 1'b0;
      end
      Run = 1'($urandom_range(1));
      Continue = 1'($urandom_range(1));
      case (mode)
        M_HALT:
          if (Run) begin
            q.push_back(fetch_w());
            new_instr = 1'b1;
            mode = M_Q;
          end
        M_Q: begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            if (pause_pending) begin
              mode = M_P1;
              pause_pending = 1'b0;
            end else begin
              q.push_back(fetch_w());
              new_instr = 1'b1;
            end
          end
        end
        M_P1: if (Continue) mode = M_P2;
        default:
          if (!Continue) begin
            q.push_back(fetch_w());
            new_instr = 1'b1;
            mode = M_Q;
          end
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
